// File: rtl/fetch_ifid_stage.sv
// Fetch stage plus IF/ID pipeline register for the 16-bit WISC pipeline.
// Optional stall/bubble performance counters when FETCH_PERF_CNT_EN is defined.
module fetch_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [15:0] PC_STEP   = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        imem_stall,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] bubble_cnt,
`endif
    output logic        halted
);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_inc: 16'h0000, valid: 1'b0};

    logic [15:0] pc;
    logic [15:0] pc_next_seq;
    logic        is_halt;
    ifid_t       ifid;

    assign pc_next_seq = pc + PC_STEP;
    assign is_halt     = (imem_instr[15:11] == 5'b00000);

    assign imem_addr   = pc;
    assign ifid_instr  = ifid.instr;
    assign ifid_pc_inc = ifid.pc_inc;
    assign ifid_valid  = ifid.valid;

    // Priority: redirect > stall_in > halted > imem_stall > normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            ifid   <= BUBBLE;
            halted <= 1'b0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            ifid   <= BUBBLE;
            halted <= 1'b0;
        end else if (stall_in) begin
            pc     <= pc;
        end else if (halted || imem_stall) begin
            ifid   <= BUBBLE;
        end else begin
            // A HALT is latched like any instruction but freezes the PC behind it.
            pc     <= is_halt ? pc : pc_next_seq;
            ifid   <= '{instr: imem_instr, pc_inc: pc_next_seq, valid: 1'b1};
            halted <= is_halt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = stall_in && !redirect;
    assign bubble_evt = redirect || (!stall_in && (halted || imem_stall));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= 16'h0000;
            bubble_cnt <= 16'h0000;
        end else begin
            if (stall_evt && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (bubble_evt && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
Fetch stage plus IF/ID pipeline register for the 16-bit WISC pipeline.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+2 into IF/ID.
- Applies the hazard unit's STALL (hold), branch/jump redirect (flush) and instruction-memory not-ready (bubble).
- Latches HALT so fetch stops cleanly.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, encoding injected into IF/ID as a bubble (WISC NOP).
PC_STEP, 2, PC increment per accepted fetch (bytes).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  16  fetch address; equals current PC (combinational from PC register)
imem_instr  input  16  instruction returned for imem_addr in the same cycle
imem_stall  input  1  1 = imem_instr not valid this cycle
stall_in  input  1  hazard-unit STALL; 1 = hold PC and IF/ID
redirect  input  1  taken branch/jump resolved downstream; flush and load new PC
redirect_pc  input  16  target PC when redirect=1
ifid_instr  output  16  IF/ID instruction register
ifid_pc_inc  output  16  IF/ID PC+PC_STEP of the latched instruction
ifid_valid  output  1  1 = IF/ID holds a real fetched instruction
halted  output  1  HALT (opcode 00000) accepted into IF/ID; fetch frozen

Behaviour:
- Reset (asserted at any time, including mid-stall or mid-redirect) takes effect immediately and overrides all inputs:
  - pc = RESET_PC, ifid_instr = NOP_INSTR, ifid_pc_inc = 16'h0000, ifid_valid = 0, halted = 0.
- Per rising edge, priority order is redirect > stall_in > halted > imem_stall > normal.
- redirect=1:
  - pc <= redirect_pc.
  - IF/ID <= bubble: instr = NOP_INSTR, pc_inc = 16'h0000, valid = 0.
  - halted <= 0.
  - stall_in and imem_stall are ignored this cycle.
- stall_in=1 (no redirect): pc, IF/ID and halted all hold their values.
- halted=1 (no redirect, no stall):
  - pc holds.
  - IF/ID <= bubble.
  - imem_instr is ignored.
- imem_stall=1 (otherwise): pc holds; IF/ID <= bubble.
- Normal fetch:
  - pc <= pc + PC_STEP, modulo 2^16 (16'hFFFE + 2 = 16'h0000, no flag).
  - ifid_instr <= imem_instr; ifid_pc_inc <= pc + PC_STEP; ifid_valid <= 1.
  - If imem_instr[15:11] == 5'b00000, halted <= 1 from the next cycle and pc holds instead of incrementing.
- A HALT seen while stall_in or imem_stall is 1 is not accepted and does not set halted.
- Latency: an instruction at PC fetched in cycle N appears on ifid_* after edge N.
- Stall-then-redirect: redirect wins, so no instruction is lost or duplicated.
- No combinational path from stall_in, redirect or imem_stall to any output except through registers. imem_addr depends only on the pc register.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds two output ports.
  - stall_cnt (16): counts cycles with stall_in=1 and redirect=0.
  - bubble_cnt (16): counts edges where IF/ID loads a bubble because of redirect, halted or imem_stall.
  - Both counters are cleared by rst and saturate at 16'hFFFF.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem returns 16'h4000,16'h4100 at PC 0,2, no stalls -> imem_addr 0,2,4; ifid_instr 16'h4000 then 16'h4100; ifid_pc_inc 2 then 4; ifid_valid 1.
- stall_in=1 for 2 cycles after the first fetch -> pc stays 2 and ifid_instr stays 16'h4000 for both cycles; fetch resumes at PC 2.
- redirect=1, redirect_pc=16'h0040 while stall_in=1 -> next cycle imem_addr=16'h0040, ifid_instr=16'h0800, ifid_valid=0.
- imem_stall=1 for 3 cycles at PC 6 -> imem_addr stays 6; three bubbles (valid 0, instr 16'h0800); then the instruction at 6 is latched with pc_inc 8.
- imem_instr=16'h0000 (HALT) at PC 8 -> ifid_instr 16'h0000, halted=1, pc frozen at 8, subsequent IF/ID bubbles; a later redirect to 16'h0010 clears halted and fetches from 16'h0010.
- Reset asserted mid-stall with pc=16'h0020 -> outputs return to reset values immediately, with no clock edge needed; with FETCH_PERF_CNT_EN, stall_cnt and bubble_cnt read 0.
